inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage sitting directly downstream of the PC branch-prediction stage. It takes the predicted PC each cycle and issues a single-outstanding read to instruction memory. It returns the fetched word, tagged with its PC, to the decode stage. It raises a stall request while a fetch is in flight and discards stale responses after a flush. Misaligned PCs are trapped without touching memory.

## Interface
Parameters:
- `RESET_PC`, `32'hbfc0_0000`: value driven on `pc_out` during and after reset.

Ports:
- `clk`  in  1  stage clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  kill in-flight and held instruction; highest priority after `rst`.
- `stall_current_stage`  in  1  controller freezes this stage; no new PC accepted.
- `stall_next_stage`  in  1  decode not accepting; output must hold.
- `pc_in`  in  32  PC from the prediction stage, sampled when accepted.
- `ram_en`  out  1  memory request strobe.
- `ram_addr`  out  32  request address, word aligned.
- `ram_ready`  in  1  memory accepts request this cycle when `ram_en & ram_ready`.
- `ram_rvalid`  in  1  response valid, at least 1 cycle after acceptance.
- `ram_rdata`  in  32  response data, valid with `ram_rvalid`.
- `stall_req`  out  1  asks the controller to stall upstream stages.
- `valid_out`  out  1  `pc_out`/`inst_out` hold a real instruction.
- `pc_out`  out  32  PC of the presented instruction.
- `inst_out`  out  32  fetched instruction word.
- `adel_out`  out  1  fetch address error; `pc_out` is the offending PC.

## Operation
- States:
  - IDLE: no request.
  - REQ: `ram_en` high, waiting for `ram_ready`.
  - WAIT: accepted, waiting for `ram_rvalid`.
  - DROP: flushed while in flight, draining one response.
  - HOLD: result captured but `stall_next_stage` was high.
- Accept rule: in IDLE, when neither stall input is set, `pc_in` is latched.
  - If `pc_in[1:0] != 0`: go straight to output with `adel_out=1`, `inst_out=0`, `valid_out=1`, no memory access, stay IDLE.
  - Else: go to REQ with `ram_addr = pc_in`.
- REQ: hold `ram_en=1` and `ram_addr` stable until `ram_ready`, then go to WAIT. Acceptance and `ram_rvalid` in the same cycle is illegal for memory.
- WAIT on `ram_rvalid`:
  - If `stall_next_stage=0`: register `ram_rdata` and PC to the outputs with `valid_out=1`, then go to IDLE.
  - If `stall_next_stage=1`: capture into the hold register and go to HOLD.
- HOLD: keep outputs frozen; on `stall_next_stage=0`, present the held result and go to IDLE.
- `stall_req = (state==REQ) | (state==WAIT) | (state==DROP)`.
- Flush, by state:
  - REQ: drop `ram_en` next cycle; go to IDLE.
  - WAIT: go to DROP.
  - DROP: drain the response, then go to IDLE.
  - HOLD: discard the held result; go to IDLE.
  - Outputs in every case: `valid_out=0`, `adel_out=0`.
- Flush coinciding with `ram_rvalid` in WAIT: the response is discarded and the next state is IDLE, not DROP.
- Output register hold: with `stall_next_stage=1`, `valid_out`, `pc_out`, `inst_out` and `adel_out` keep their values. If `stall_next_stage=0` and there is no new result, `valid_out` clears to 0 the next cycle.

## Timing
- Reset values: state=IDLE, `ram_en=0`, `ram_addr=0`, `stall_req=0`, `valid_out=0`, `pc_out=RESET_PC`, `inst_out=0`, `adel_out=0`.
- Reset asserted mid-request abandons it; a later stray `ram_rvalid` in IDLE is ignored.
- Latency: PC accepted at edge N gives `ram_en` high after N.
  - With `ram_ready` in the same cycle and `ram_rvalid` one cycle later, `valid_out` rises after edge N+2.
  - Each extra memory wait cycle adds one.
- Misaligned PC: `valid_out`/`adel_out` rise after edge N+1.
- `ram_rvalid` in IDLE or REQ is ignored.
- `stall_current_stage` does not cancel a REQ already issued; it only blocks new acceptance.

## Test plan
- Aligned fetch:
  - Stimulus: `pc_in=0x1000`, `ram_ready=1`, `ram_rvalid` one cycle later with `ram_rdata=0x24020001`.
  - Required: `valid_out=1`, `pc_out=0x1000`, `inst_out=0x24020001` two edges after accept; `stall_req` high for exactly the two in-flight cycles.
- Back-pressure:
  - Stimulus: `ram_ready` low 3 cycles, then `stall_next_stage=1` when the response arrives, held 2 cycles.
  - Required: `ram_addr` stable during REQ; outputs appear only after the stall releases; the value presented is unchanged from the captured response.
- Flush in WAIT:
  - Stimulus: flush one cycle after acceptance; the response arrives two cycles later with `0xdeadbeef`.
  - Required: `valid_out` stays 0, `0xdeadbeef` never appears, `stall_req` drops after the drained response.
- Flush coinciding with `ram_rvalid`:
  - Required: no output, next state IDLE.
  - Required: the next PC, `0x2000`, fetches normally.
- Misaligned PC:
  - Stimulus: `pc_in=0x1002`.
  - Required: `ram_en` never asserted; `adel_out=1`, `valid_out=1`, `pc_out=0x1002`, `inst_out=0`.
- Reset mid-WAIT:
  - Stimulus: `rst` pulsed asynchronously between clock edges while in WAIT.
  - Required: outputs go immediately to reset values, `pc_out=RESET_PC`; a late `ram_rvalid` is ignored.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: takes the predicted PC, issues one outstanding memory read,
// and presents the fetched word (tagged with its PC) to decode, trapping misaligned PCs.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_current_stage,
  input  logic        stall_next_stage,
  input  logic [31:0] pc_in,
  output logic        ram_en,
  output logic [31:0] ram_addr,
  input  logic        ram_ready,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata,
  output logic        stall_req,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        adel_out,
  output logic [2:0]  dbg_state_o
);

  // Memory handshake: a request is taken on a cycle with ram_en & ram_ready; the single
  // response comes back on a later cycle with ram_rvalid. Decode consumes a result on a
  // cycle where valid_out is high and stall_next_stage is low.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t      state_q;
  logic        ram_en_q;
  logic [31:0] ram_addr_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        adel_q;
  logic [31:0] hold_inst_q;
  logic        adel_pend_q;
  logic [31:0] adel_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      valid_q     <= 1'b0;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      adel_q      <= 1'b0;
      hold_inst_q <= '0;
      adel_pend_q <= 1'b0;
      adel_pc_q   <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      adel_q      <= 1'b0;
      adel_pend_q <= 1'b0;
      ram_en_q    <= 1'b0;
      case (state_q)
        // An in-flight response must still be drained unless it is arriving right now.
        S_WAIT, S_DROP: state_q <= ram_rvalid ? S_IDLE : S_DROP;
        default:        state_q <= S_IDLE;
      endcase
    end else begin
      if (!stall_next_stage) begin
        valid_q <= 1'b0;
        adel_q  <= 1'b0;
      end
      // A misaligned PC is presented one cycle after it was latched.
      if (adel_pend_q && !stall_next_stage) begin
        valid_q     <= 1'b1;
        adel_q      <= 1'b1;
        pc_q        <= adel_pc_q;
        inst_q      <= '0;
        adel_pend_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!stall_current_stage && !stall_next_stage) begin
            if (pc_in[1:0] != 2'b00) begin
              adel_pend_q <= 1'b1;
              adel_pc_q   <= pc_in;
            end else begin
              state_q    <= S_REQ;
              ram_en_q   <= 1'b1;
              ram_addr_q <= pc_in;
            end
          end
        end
        S_REQ: begin
          if (ram_ready) begin
            state_q  <= S_WAIT;
            ram_en_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (ram_rvalid) begin
            if (!stall_next_stage) begin
              valid_q <= 1'b1;
              adel_q  <= 1'b0;
              pc_q    <= ram_addr_q;
              inst_q  <= ram_rdata;
              state_q <= S_IDLE;
            end else begin
              hold_inst_q <= ram_rdata;
              state_q     <= S_HOLD;
            end
          end
        end
        S_DROP: begin
          if (ram_rvalid) state_q <= S_IDLE;
        end
        S_HOLD: begin
          // ram_addr_q still carries the PC of the held word; no new request was issued.
          if (!stall_next_stage) begin
            valid_q <= 1'b1;
            adel_q  <= 1'b0;
            pc_q    <= ram_addr_q;
            inst_q  <= hold_inst_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_addr    = ram_addr_q;
  assign stall_req   = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DROP);
  assign valid_out   = valid_q;
  assign pc_out      = pc_q;
  assign inst_out    = inst_q;
  assign adel_out    = adel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized fetches, checked against
// a word-level memory model and an expected-result queue.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
  localparam logic [2:0]  IDLE_CODE = 3'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        stall_current_stage = 1'b1;
  logic        stall_next_stage = 1'b0;
  logic [31:0] pc_in = '0;
  logic        ram_en;
  logic [31:0] ram_addr;
  logic        ram_ready = 1'b0;
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        stall_req;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        adel_out;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_current_stage(stall_current_stage), .stall_next_stage(stall_next_stage),
    .pc_in(pc_in), .ram_en(ram_en), .ram_addr(ram_addr), .ram_ready(ram_ready),
    .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata), .stall_req(stall_req),
    .valid_out(valid_out), .pc_out(pc_out), .inst_out(inst_out), .adel_out(adel_out),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic check_result(input string tag, input logic adel);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, valid_out, 1);
      chk({tag, "_adel"}, adel_out, adel);
      chk({tag, "_pc"}, pc_out, e[63:32]);
      chk({tag, "_inst"}, inst_out, e[31:0]);
    end
  endtask

  // fl: 0 = normal, 1 = flush together with the response, 2 = flush while waiting
  task automatic fetch(input logic [31:0] pc, input int w, input int d, input int h, input int fl);
    logic [31:0] word;
    word = mem_word(pc);
    pc_in = pc;
    stall_current_stage = 1'b0;
    stall_next_stage = 1'b0;
    step();
    stall_current_stage = 1'b1;
    pc_in = $urandom;
    chk("req_en", ram_en, 1);
    chk("req_addr", ram_addr, pc);
    chk("req_stall", stall_req, 1);
    for (int i = 0; i < w; i++) begin
      step();
      chk("req_hold_en", ram_en, 1);
      chk("req_addr_stable", ram_addr, pc);
    end
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0;
    chk("acc_en", ram_en, 0);
    chk("acc_stall", stall_req, 1);
    chk("acc_valid", valid_out, 0);
    if (fl == 2) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("drop_stall", stall_req, 1);
      chk("drop_valid", valid_out, 0);
    end
    for (int i = 0; i < d; i++) begin
      step();
      chk("inflight_stall", stall_req, 1);
      chk("inflight_valid", valid_out, 0);
    end
    ram_rvalid = 1'b1;
    ram_rdata = word;
    flush = (fl == 1);
    stall_next_stage = (h > 0) && (fl == 0);
    step();
    ram_rvalid = 1'b0;
    ram_rdata = $urandom;
    flush = 1'b0;
    chk("resp_stall", stall_req, 0);
    if (fl != 0) begin
      chk("flushed_valid", valid_out, 0);
      chk("flushed_adel", adel_out, 0);
      chk("flushed_no_stale", 32'(inst_out === word), 0);
      if (fl == 1) chk("flushed_state_idle", 32'(dbg_state), 32'(IDLE_CODE));
      step();
      chk("flushed_later_valid", valid_out, 0);
    end else begin
      exp_q.push_back({pc, word});
      if (h > 0) begin
        chk("hold_valid", valid_out, 0);
        for (int i = 1; i < h; i++) begin
          step();
          chk("hold_valid", valid_out, 0);
        end
        stall_next_stage = 1'b0;
        step();
      end
      check_result("fetch", 1'b0);
      step();
      chk("valid_clear", valid_out, 0);
      chk("pc_kept", pc_out, pc);
    end
    stall_next_stage = 1'b0;
  endtask

  task automatic fetch_mis(input logic [31:0] pc);
    pc_in = pc;
    stall_current_stage = 1'b0;
    stall_next_stage = 1'b0;
    step();
    stall_current_stage = 1'b1;
    pc_in = $urandom;
    exp_q.push_back({pc, 32'h0});
    chk("mis_en0", ram_en, 0);
    chk("mis_stall", stall_req, 0);
    chk("mis_early_valid", valid_out, 0);
    step();
    chk("mis_en1", ram_en, 0);
    check_result("mis", 1'b1);
    step();
    chk("mis_en2", ram_en, 0);
    chk("mis_clear_valid", valid_out, 0);
    chk("mis_clear_adel", adel_out, 0);
  endtask

  initial begin
    logic [31:0] r;
    int kind;
    #1 rst = 1'b1;
    #2;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_stall_req", stall_req, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_inst", inst_out, 0);
    chk("rst_adel", adel_out, 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE_CODE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    mem[32'h1000] = 32'h2402_0001;
    fetch(32'h1000, 0, 0, 0, 0);
    fetch(32'h1004, 3, 0, 2, 0);
    mem[32'h1100] = 32'hdead_beef;
    fetch(32'h1100, 0, 1, 0, 2);
    fetch(32'h1200, 0, 0, 0, 1);
    fetch(32'h2000, 0, 0, 0, 0);
    fetch_mis(32'h1002);

    // asynchronous reset while a read is outstanding
    pc_in = 32'h3000;
    stall_current_stage = 1'b0;
    step();
    stall_current_stage = 1'b1;
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0;
    chk("pre_rst_stall", stall_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_pc", pc_out, RESET_PC);
    chk("midrst_stall", stall_req, 0);
    chk("midrst_addr", ram_addr, 0);
    #1 rst = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata = 32'h1234_5678;
    step();
    ram_rvalid = 1'b0;
    chk("late_rvalid_valid", valid_out, 0);
    chk("late_rvalid_pc", pc_out, RESET_PC);
    chk("late_rvalid_stall", stall_req, 0);
    chk("late_rvalid_en", ram_en, 0);
    fetch(32'h3004, 1, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        fetch_mis({r[31:2], 2'($urandom_range(1, 3))});
      end else begin
        kind = $urandom_range(0, 5);
        fetch({r[31:2], 2'b00}, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), (kind < 4) ? 0 : kind - 3);
      end
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
